// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake
// and produces the IR load pulse, with redirect and timeout handling.
module fetch_ctrl #(
    parameter int              AW      = 16,
    parameter logic [AW-1:0]   PC_RST  = '0,
    parameter int              TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic          ir_load,
    output logic [15:0]   ir_data,
    output logic [AW-1:0] pc,
    output logic          instr_valid,
    output logic          fetch_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

    logic [1:0]    state;
    logic [7:0]    tcnt;
    logic          pend;
    logic [AW-1:0] pend_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= PC_RST;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            ir_load     <= 1'b0;
            ir_data     <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            tcnt        <= '0;
            pend        <= 1'b0;
            pend_addr   <= '0;
        end else begin
            ir_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (redirect)
                        pc <= redirect_addr;
                    if (run) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect ? redirect_addr : pc;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        tcnt    <= '0;
                        mem_req <= 1'b0;
                        pend    <= 1'b0;
                        // Stale data after a redirect; IDLE gives the one-cycle gap.
                        if (pend || redirect) begin
                            pc    <= redirect ? redirect_addr : pend_addr;
                            state <= IDLE;
                        end else begin
                            ir_data     <= mem_rdata;
                            ir_load     <= 1'b1;
                            pc          <= pc + AW'(1);
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (tcnt + 8'd1 == TO_MAX) begin
                        state     <= ERR;
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        tcnt      <= '0;
                        pend      <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (redirect) begin
                            pend      <= 1'b1;
                            pend_addr <= redirect_addr;
                        end
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        instr_valid <= 1'b0;
                        if (redirect)
                            pc <= redirect_addr;
                        if (run) begin
                            state    <= FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= redirect ? redirect_addr : pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then random traffic checked
// against a transaction-level model of the fetch address stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ir_load;
    logic [15:0] ir_data;
    logic [15:0] pc;
    logic        instr_valid;
    logic        fetch_err;

    logic        run2 = 1'b0;
    logic        mem_req2;
    logic [15:0] mem_addr2;
    logic        mem_ack2;
    logic        ir_load2;
    logic [15:0] ir_data2;
    logic [15:0] pc2;
    logic        instr_valid2;
    logic        fetch_err2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.AW(16), .PC_RST(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_load(ir_load), .ir_data(ir_data), .pc(pc),
        .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    // Zero-wait memory for the wrap-around instance.
    assign mem_ack2 = mem_req2;

    fetch_ctrl #(.AW(16), .PC_RST(16'hFFFF), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .stall(1'b0),
        .redirect(1'b0), .redirect_addr(16'h0000),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack2), .mem_rdata(16'hA5A5),
        .ir_load(ir_load2), .ir_data(ir_data2), .pc(pc2),
        .instr_valid(instr_valid2), .fetch_err(fetch_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {31'd0, mem_req}, 0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 0);
        chk({tag, "_load"}, {31'd0, ir_load}, 0);
        chk({tag, "_data"}, {16'd0, ir_data}, 0);
        chk({tag, "_pc"}, {16'd0, pc}, 0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 0);
        chk({tag, "_err"}, {31'd0, fetch_err}, 0);
    endtask

    // Random-phase model state
    logic [15:0] exp_addr, exp_data, exp_pc, pend_tgt, prev_addr, prev_data;
    logic        exp_load, exp_drop, pend_m, prev_req, prev_ack, prev_hs;
    int          wait_left;

    initial begin
        repeat (3) step();
        chk_reset_vals("rst0");
        chk("rst0_pc2", {16'd0, pc2}, 32'hFFFF);
        rst = 1'b1;
        run = 1'b1;

        // Zero-wait fetch at address 0
        step();
        chk("t1_req", {31'd0, mem_req}, 1);
        chk("t1_addr", {16'd0, mem_addr}, 0);
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        chk("t1_load", {31'd0, ir_load}, 1);
        chk("t1_data", {16'd0, ir_data}, 32'h1234);
        chk("t1_valid", {31'd0, instr_valid}, 1);
        chk("t1_pc", {16'd0, pc}, 1);
        chk("t1_reqlow", {31'd0, mem_req}, 0);
        step();
        chk("t1_req2", {31'd0, mem_req}, 1);
        chk("t1_addr2", {16'd0, mem_addr}, 1);
        chk("t1_consumed", {31'd0, instr_valid}, 0);

        // Delayed ack, then stalled HOLD
        repeat (3) begin
            step();
            chk("t2_wait_req", {31'd0, mem_req}, 1);
            chk("t2_wait_addr", {16'd0, mem_addr}, 1);
        end
        mem_ack = 1'b1;
        mem_rdata = 16'h5678;
        stall = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t2_valid", {31'd0, instr_valid}, 1);
        chk("t2_data", {16'd0, ir_data}, 32'h5678);
        repeat (4) begin
            step();
            chk("t2_hold_valid", {31'd0, instr_valid}, 1);
            chk("t2_hold_data", {16'd0, ir_data}, 32'h5678);
            chk("t2_hold_req", {31'd0, mem_req}, 0);
            chk("t2_hold_load", {31'd0, ir_load}, 0);
        end
        stall = 1'b0;
        step();
        chk("t2_req", {31'd0, mem_req}, 1);
        chk("t2_addr", {16'd0, mem_addr}, 2);

        // Walk to address 5, then redirect mid-fetch
        for (int k = 2; k <= 4; k++) begin
            mem_ack = 1'b1;
            mem_rdata = 16'(k);
            step();
            mem_ack = 1'b0;
            step();
            chk("t3_walk", {16'd0, mem_addr}, 32'(k + 1));
        end
        redirect = 1'b1;
        redirect_addr = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t3_inflight_req", {31'd0, mem_req}, 1);
        chk("t3_inflight_addr", {16'd0, mem_addr}, 5);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        chk("t3_noload", {31'd0, ir_load}, 0);
        chk("t3_data_kept", {16'd0, ir_data}, 4);
        chk("t3_gap", {31'd0, mem_req}, 0);
        chk("t3_pc", {16'd0, pc}, 32'h40);
        step();
        chk("t3_req", {31'd0, mem_req}, 1);
        chk("t3_addr", {16'd0, mem_addr}, 32'h40);

        // Redirect during stalled HOLD
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        stall = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t4_valid", {31'd0, instr_valid}, 1);
        redirect = 1'b1;
        redirect_addr = 16'h0010;
        step();
        redirect = 1'b0;
        chk("t4_drop", {31'd0, instr_valid}, 0);
        chk("t4_req", {31'd0, mem_req}, 1);
        chk("t4_addr", {16'd0, mem_addr}, 32'h10);
        stall = 1'b0;

        // Timeout into ERR
        repeat (14) begin
            step();
            chk("t5_wait_req", {31'd0, mem_req}, 1);
            chk("t5_wait_err", {31'd0, fetch_err}, 0);
        end
        step();
        chk("t5_err", {31'd0, fetch_err}, 1);
        chk("t5_req", {31'd0, mem_req}, 0);
        repeat (3) begin
            redirect = 1'b1;
            redirect_addr = 16'h0077;
            step();
            chk("t5_stuck_err", {31'd0, fetch_err}, 1);
            chk("t5_stuck_req", {31'd0, mem_req}, 0);
            chk("t5_stuck_valid", {31'd0, instr_valid}, 0);
            chk("t5_stuck_pc", {16'd0, pc}, 32'h10);
        end
        redirect = 1'b0;
        rst = 1'b0;
        #2;
        chk_reset_vals("t5_async");
        step();
        rst = 1'b1;
        run = 1'b0;

        // PC wrap from PC_RST = 0xFFFF
        run2 = 1'b1;
        step();
        chk("t6_req", {31'd0, mem_req2}, 1);
        chk("t6_addr", {16'd0, mem_addr2}, 32'hFFFF);
        step();
        chk("t6_pc", {16'd0, pc2}, 0);
        chk("t6_load", {31'd0, ir_load2}, 1);
        chk("t6_data", {16'd0, ir_data2}, 32'hA5A5);
        step();
        chk("t6_addr0", {16'd0, mem_addr2}, 0);
        chk("t6_err", {31'd0, fetch_err2 | instr_valid2}, 0);
        run2 = 1'b0;

        // Random traffic
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_addr = 16'h0000;
        exp_data = '0;
        exp_pc = '0;
        pend_tgt = '0;
        prev_addr = '0;
        prev_data = '0;
        exp_load = 1'b0;
        exp_drop = 1'b0;
        pend_m = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_hs = 1'b0;
        wait_left = 0;
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom % 10) != 0;
            stall = ($urandom % 5) < 2;
            redirect = ($urandom % 10) == 0;
            redirect_addr = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!prev_req)
                    wait_left = $urandom_range(0, 3);
                mem_ack = (wait_left == 0);
                if (wait_left != 0)
                    wait_left--;
            end
            exp_load = 1'b0;
            exp_drop = redirect && instr_valid;
            if (mem_req && mem_ack) begin
                if (pend_m || redirect) begin
                    exp_addr = redirect ? redirect_addr : pend_tgt;
                end else begin
                    exp_load = 1'b1;
                    exp_data = mem_rdata;
                    exp_pc = mem_addr + 16'd1;
                    exp_addr = mem_addr + 16'd1;
                end
                pend_m = 1'b0;
            end else if (redirect) begin
                if (mem_req) begin
                    pend_m = 1'b1;
                    pend_tgt = redirect_addr;
                end
                exp_addr = redirect_addr;
            end
            prev_req = mem_req;
            prev_ack = mem_req && mem_ack;
            prev_addr = mem_addr;
            prev_hs = instr_valid && stall && !redirect;
            prev_data = ir_data;

            step();
            chk("r_load", {31'd0, ir_load}, {31'd0, exp_load});
            if (exp_load) begin
                chk("r_data", {16'd0, ir_data}, {16'd0, exp_data});
                chk("r_valid", {31'd0, instr_valid}, 1);
                chk("r_pc", {16'd0, pc}, {16'd0, exp_pc});
            end
            if (prev_req && !prev_ack) begin
                chk("r_req_hold", {31'd0, mem_req}, 1);
                chk("r_addr_stable", {16'd0, mem_addr}, {16'd0, prev_addr});
            end
            if (prev_ack)
                chk("r_req_drop", {31'd0, mem_req}, 0);
            if (mem_req && !prev_req) begin
                chk("r_fetch_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
                chk("r_fetch_pc", {16'd0, pc}, {16'd0, exp_addr});
            end
            if (prev_hs) begin
                chk("r_stall_valid", {31'd0, instr_valid}, 1);
                chk("r_stall_data", {16'd0, ir_data}, {16'd0, prev_data});
            end
            if (exp_drop)
                chk("r_redir_drop", {31'd0, instr_valid}, 0);
            chk("r_err", {31'd0, fetch_err}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the s_proc datapath.
- Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Generates the load pulse and data for the 16-bit instruction register.
- Holds a fetched instruction valid until decode/execute consumes it; handles branch redirects and memory timeouts.

Parameters:
- AW, 16, program-counter and memory-address width in bits.
- PC_RST, 0, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles in FETCH without mem_ack before error. Legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = fetching enabled.
- stall  input  1  1 = downstream not ready; hold current instruction.
- redirect  input  1  single-cycle pulse; load PC from redirect_addr.
- redirect_addr  input  AW  branch/jump target.
- mem_req  output  1  instruction-memory read request.
- mem_addr  output  AW  read address; stable while mem_req=1.
- mem_ack  input  1  memory acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  input  16  instruction word from memory.
- ir_load  output  1  one-cycle load enable to the instruction register.
- ir_data  output  16  registered instruction word, feeds the IR input.
- pc  output  AW  address of the next instruction to fetch.
- instr_valid  output  1  fetched instruction held and not yet consumed.
- fetch_err  output  1  sticky fetch-timeout flag.

Behaviour:
- Clock and reset: single clock domain, posedge clk. All outputs are registered.
- Reset values (rst=0, asynchronous):
  - state=IDLE, pc=PC_RST.
  - mem_req=0, mem_addr=0, ir_load=0, ir_data=0, instr_valid=0, fetch_err=0.
  - Timeout counter=0, pending-redirect flag=0.
- Reset mid-transaction aborts immediately; no handshake completion is required.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE:
  - run=1 → FETCH. mem_req=1 and mem_addr=pc are registered in the same edge.
  - run=0 → stay in IDLE.
- FETCH:
  - mem_req held at 1 and mem_addr held stable until mem_ack. mem_req is never dropped before ack.
  - Timeout counter increments each FETCH cycle without ack; cleared on ack or on leaving FETCH.
  - On mem_ack with no pending redirect:
    - ir_data<=mem_rdata; ir_load=1 for exactly the next cycle.
    - pc<=pc+1, modulo 2^AW (0xFFFF wraps to 0x0000).
    - mem_req<=0, instr_valid<=1, → HOLD.
  - Timeout: counter reaches TIMEOUT without ack → ERR. mem_req<=0, fetch_err<=1.
- HOLD:
  - instr_valid=1; ir_data stable.
  - stall=0 consumes the instruction: instr_valid<=0.
  - After consume: run=1 → FETCH (mem_req<=1, mem_addr<=pc); run=0 → IDLE.
  - stall=1 → remain in HOLD indefinitely.
- ERR: mem_req=0, instr_valid=0, fetch_err=1. Exit only via reset.
- Throughput: with zero-wait memory (ack in the first FETCH cycle) and stall=0, one instruction per 2 cycles.
- Redirect (ignored in ERR):
  - IDLE: pc<=redirect_addr.
  - HOLD: pc<=redirect_addr, instr_valid<=0, held instruction discarded; → FETCH if run=1, else IDLE. Has priority over stall.
  - FETCH:
    - Sets the pending flag and latches the target; the in-flight request still completes.
    - On ack with pending flag set: data discarded (no ir_load, ir_data unchanged), pc<=target, pending cleared.
    - Then re-enter FETCH at the new address, with mem_req low for exactly one cycle between requests. If run=0, go to IDLE instead.
    - Redirect coincident with ack in FETCH: treated as pending, so the data is discarded.
    - Multiple redirects before ack: latest target wins.
- run deasserted during FETCH: the current fetch completes normally → HOLD → IDLE after consume.
- pc never changes except on ack (increment) or redirect.

Test Plan:
- Reset, run=1, memory acks the first FETCH cycle with 0x1234 at addr 0 → mem_req at cycle 1, ir_load pulse with ir_data=0x1234, instr_valid=1, pc=1; next request at addr 1 two cycles later.
- Memory ack delayed 3 cycles, stall=1 for 4 cycles in HOLD → mem_addr stable during wait; instr_valid and ir_data held through the stall; next mem_req only after stall=0.
- Redirect to 0x0040 asserted during FETCH at addr 5 (ack 2 cycles later, rdata 0xBEEF) → no ir_load, ir_data unchanged, mem_req low one cycle, then mem_addr=0x0040.
- Redirect to 0x0010 during HOLD with stall=1 → instr_valid drops next cycle, then FETCH at 0x0010.
- No ack for TIMEOUT=15 cycles → ERR: fetch_err=1, mem_req=0; stays in ERR despite run and redirect until rst low, then all outputs return to reset values.
- PC_RST=0xFFFF, one fetch acked → pc wraps to 0x0000; next mem_addr=0x0000.
